// File: rtl/exc_pkg.sv
// Shared definitions for the exception/interrupt controller: PC-select codes,
// controller states, trap vector addresses and the normal-flow decode helper.
package exc_pkg;

  // PC-select codes consumed by the PC-update unit
  localparam logic [2:0] PCSRC_NORMAL = 3'b000;  // PC + 4
  localparam logic [2:0] PCSRC_BRANCH = 3'b001;  // branch target
  localparam logic [2:0] PCSRC_JUMP   = 3'b010;  // jump target
  localparam logic [2:0] PCSRC_JR     = 3'b011;  // DataBusA (register or EPC)
  localparam logic [2:0] PCSRC_ILLOP  = 3'b100;  // interrupt vector
  localparam logic [2:0] PCSRC_XADR   = 3'b101;  // exception vector

  // Vector addresses the PC-update unit jumps to for codes 100 and 101
  localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC  = 32'h8000_0008;

  typedef enum logic {
    ST_USER   = 1'b0,
    ST_KERNEL = 1'b1
  } exc_state_e;

  // Fixed priority jr > jump > branch, regardless of how many flags are set
  function automatic logic [2:0] normal_pcsrc(input logic jr, input logic jump,
                                              input logic branch);
    logic [2:0] sel;
    if (jr) begin
      sel = PCSRC_JR;
    end else if (jump) begin
      sel = PCSRC_JUMP;
    end else if (branch) begin
      sel = PCSRC_BRANCH;
    end else begin
      sel = PCSRC_NORMAL;
    end
    return sel;
  endfunction

endpackage

// File: rtl/irq_edge_det.sv
// Rising-edge detector for the external interrupt line.
// Config macro: EXC_CTRL_IRQ_SYNC_EN adds a two-flop synchroniser in front of
// the detector (two extra cycles of latency); without it irq must already be
// synchronous to clk.
// The flops here deliberately have no reset: they keep tracking the line level
// through reset, so a level that is already high when reset is released is not
// mistaken for a fresh edge.
module irq_edge_det (
  input  logic clk,
  input  logic irq,
  output logic irq_rise
);

  logic irq_lvl;

`ifdef EXC_CTRL_IRQ_SYNC_EN
  logic sync1_d, sync1_q;
  logic sync2_d, sync2_q;

  // Synchroniser next-state: plain shift
  always_comb begin
    sync1_d = irq;
    sync2_d = sync1_q;
  end

  // Two-flop synchroniser registers
  always_ff @(posedge clk) begin
    sync1_q <= sync1_d;
    sync2_q <= sync2_d;
  end

  assign irq_lvl = sync2_q;
`else
  assign irq_lvl = irq;
`endif

  logic prev_d, prev_q;

  // Previous-level next-state
  always_comb begin
    prev_d = irq_lvl;
  end

  // Previous-level register
  always_ff @(posedge clk) begin
    prev_q <= prev_d;
  end

  assign irq_rise = irq_lvl & ~prev_q;

endmodule

// File: rtl/exc_ctrl.sv
// Exception and interrupt controller: produces the PC-select code from decode
// flags and the pending interrupt, tracks user/kernel mode and owns the EPC.
// Config macro: EXC_CTRL_IRQ_SYNC_EN (passed through to irq_edge_det).
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  input  logic        dec_branch,
  input  logic        dec_jump,
  input  logic        dec_jr,
  input  logic        dec_eret,
  input  logic        dec_illop,
  input  logic        irq,
  output logic [2:0]  PCSrc,
  output logic        a_sel_epc,
  output logic        squash,
  output logic [31:0] epc,
  output logic        kernel_mode,
  output logic        irq_ack
);

  exc_state_e  state_d, state_q;
  logic        pend_d, pend_q;
  logic [31:0] epc_d, epc_q;
  logic        irq_rise;
  logic        take_irq;
  logic [2:0]  normal_sel;

  irq_edge_det u_irq_edge_det (
    .clk      (clk),
    .irq      (irq),
    .irq_rise (irq_rise)
  );

  assign normal_sel = normal_pcsrc(dec_jr, dec_jump, dec_branch);

  // Trap/return decision and next state; outputs are combinational from inputs and state
  always_comb begin
    PCSrc     = normal_sel;
    a_sel_epc = 1'b0;
    squash    = 1'b0;
    irq_ack   = 1'b0;
    take_irq  = 1'b0;
    state_d   = state_q;
    epc_d     = epc_q;
    case (state_q)
      ST_USER: begin
        // eret has no meaning in user mode and is treated as an illegal op
        if (dec_illop || dec_eret) begin
          PCSrc   = PCSRC_XADR;
          squash  = 1'b1;
          epc_d   = pc_cur + 32'd4;
          state_d = ST_KERNEL;
        end else if (pend_q) begin
          // The current instruction is squashed and re-executed on return
          PCSrc    = PCSRC_ILLOP;
          squash   = 1'b1;
          irq_ack  = 1'b1;
          take_irq = 1'b1;
          epc_d    = pc_cur;
          state_d  = ST_KERNEL;
        end
      end
      ST_KERNEL: begin
        if (dec_eret) begin
          PCSrc     = PCSRC_JR;
          a_sel_epc = 1'b1;
          state_d   = ST_USER;
        end else if (dec_illop) begin
          // Double fault: vector again but keep the original return address
          PCSrc  = PCSRC_XADR;
          squash = 1'b1;
        end
      end
      default: begin
        state_d = ST_USER;
      end
    endcase
  end

  // Pending latch: taking the interrupt wins over a same-cycle new edge
  always_comb begin
    pend_d = pend_q;
    if (take_irq) begin
      pend_d = 1'b0;
    end else if (irq_rise) begin
      pend_d = 1'b1;
    end
  end

  // State, pending and EPC registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_USER;
      pend_q  <= 1'b0;
      epc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      epc_q   <= epc_d;
    end
  end

  assign epc         = epc_q;
  assign kernel_mode = (state_q == ST_KERNEL);

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl (default build, irq not synchronised).
// Each scenario queues per-cycle stimulus alongside the expected outputs; the
// expectation is popped and compared just before the rising edge of the cycle.
module tb_exc_ctrl;
  import exc_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_cur;
  logic        dec_branch, dec_jump, dec_jr, dec_eret, dec_illop, irq;
  logic [2:0]  PCSrc;
  logic        a_sel_epc, squash, kernel_mode, irq_ack;
  logic [31:0] epc;

  always #5 clk = ~clk;

  exc_ctrl #(
    .RESET_PC (RST_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_cur      (pc_cur),
    .dec_branch  (dec_branch),
    .dec_jump    (dec_jump),
    .dec_jr      (dec_jr),
    .dec_eret    (dec_eret),
    .dec_illop   (dec_illop),
    .irq         (irq),
    .PCSrc       (PCSrc),
    .a_sel_epc   (a_sel_epc),
    .squash      (squash),
    .epc         (epc),
    .kernel_mode (kernel_mode),
    .irq_ack     (irq_ack)
  );

  typedef struct packed {
    logic        rst_n;
    logic        br;
    logic        jmp;
    logic        jr;
    logic        eret;
    logic        illop;
    logic        irq;
    logic [31:0] pc;
  } stim_t;

  typedef struct {
    string       name;
    logic [38:0] v;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    total = 0;
  int    bad   = 0;

  function automatic stim_t st(input logic rst_n, input logic br, input logic jmp,
                               input logic jr, input logic eret, input logic illop,
                               input logic irq_l, input logic [31:0] pc);
    stim_t s;
    s.rst_n = rst_n; s.br = br; s.jmp = jmp; s.jr = jr;
    s.eret = eret; s.illop = illop; s.irq = irq_l; s.pc = pc;
    return s;
  endfunction

  // Expected output vector {PCSrc, a_sel_epc, squash, irq_ack, kernel_mode, epc}
  function automatic logic [38:0] ex(input logic [2:0] src, input logic asel, input logic sq,
                                     input logic ack, input logic km, input logic [31:0] e);
    return {src, asel, sq, ack, km, e};
  endfunction

  task automatic push(input string n, input stim_t s, input logic [38:0] v);
    exp_t e;
    e.name = n;
    e.v    = v;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic apply(input stim_t s);
    reset      = s.rst_n;
    dec_branch = s.br;
    dec_jump   = s.jmp;
    dec_jr     = s.jr;
    dec_eret   = s.eret;
    dec_illop  = s.illop;
    irq        = s.irq;
    pc_cur     = s.pc;
  endtask

  task automatic test_reset();
    stim_t s; exp_t e; logic [38:0] obs;
    push("rst_idle",    st(0,0,0,0,0,0,0,32'h0), ex(PCSRC_NORMAL,0,0,0,0,RST_PC));
    push("rst_illop",   st(0,0,0,0,0,1,0,32'h1234), ex(PCSRC_XADR,0,1,0,0,RST_PC));
    push("rst_epc_hold", st(0,0,0,0,0,0,0,32'h0), ex(PCSRC_NORMAL,0,0,0,0,RST_PC));
    push("rst_branch",  st(1,1,0,0,0,0,0,32'h00400000), ex(PCSRC_BRANCH,0,0,0,0,RST_PC));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); #4;
      e = exp_q.pop_front();
      obs = {PCSrc, a_sel_epc, squash, irq_ack, kernel_mode, epc};
      total++;
      if (obs !== e.v) begin
        bad++;
        $display("FAIL %s: got src=%b asel=%b sq=%b ack=%b km=%b epc=%h want src=%b asel=%b sq=%b ack=%b km=%b epc=%h",
                 e.name, obs[38:36], obs[35], obs[34], obs[33], obs[32], obs[31:0],
                 e.v[38:36], e.v[35], e.v[34], e.v[33], e.v[32], e.v[31:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_decode_priority();
    stim_t s; exp_t e; logic [38:0] obs;
    push("dec_jr_all",  st(1,1,1,1,0,0,0,32'h00400004), ex(PCSRC_JR,0,0,0,0,RST_PC));
    push("dec_jump_br", st(1,1,1,0,0,0,0,32'h00400008), ex(PCSRC_JUMP,0,0,0,0,RST_PC));
    push("dec_branch",  st(1,1,0,0,0,0,0,32'h0040000C), ex(PCSRC_BRANCH,0,0,0,0,RST_PC));
    push("dec_none",    st(1,0,0,0,0,0,0,32'h00400010), ex(PCSRC_NORMAL,0,0,0,0,RST_PC));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); #4;
      e = exp_q.pop_front();
      obs = {PCSrc, a_sel_epc, squash, irq_ack, kernel_mode, epc};
      total++;
      if (obs !== e.v) begin
        bad++;
        $display("FAIL %s: got src=%b asel=%b sq=%b ack=%b km=%b epc=%h want src=%b asel=%b sq=%b ack=%b km=%b epc=%h",
                 e.name, obs[38:36], obs[35], obs[34], obs[33], obs[32], obs[31:0],
                 e.v[38:36], e.v[35], e.v[34], e.v[33], e.v[32], e.v[31:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_irq();
    stim_t s; exp_t e; logic [38:0] obs;
    push("irq_edge",     st(1,0,0,0,0,0,1,32'h00400010), ex(PCSRC_NORMAL,0,0,0,0,RST_PC));
    push("irq_trap",     st(1,0,0,0,0,0,1,32'h00400010), ex(PCSRC_ILLOP,0,1,1,0,RST_PC));
    push("irq_kernel",   st(1,0,0,0,0,0,1,32'h80000004), ex(PCSRC_NORMAL,0,0,0,1,32'h00400010));
    push("irq_eret",     st(1,0,0,0,1,0,1,32'h80000008), ex(PCSRC_JR,1,0,0,1,32'h00400010));
    push("irq_back",     st(1,0,0,0,0,0,0,32'h00400010), ex(PCSRC_NORMAL,0,0,0,0,32'h00400010));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); #4;
      e = exp_q.pop_front();
      obs = {PCSrc, a_sel_epc, squash, irq_ack, kernel_mode, epc};
      total++;
      if (obs !== e.v) begin
        bad++;
        $display("FAIL %s: got src=%b asel=%b sq=%b ack=%b km=%b epc=%h want src=%b asel=%b sq=%b ack=%b km=%b epc=%h",
                 e.name, obs[38:36], obs[35], obs[34], obs[33], obs[32], obs[31:0],
                 e.v[38:36], e.v[35], e.v[34], e.v[33], e.v[32], e.v[31:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illop_with_pend();
    stim_t s; exp_t e; logic [38:0] obs;
    push("ip_edge",     st(1,0,0,0,0,0,1,32'h00400018), ex(PCSRC_NORMAL,0,0,0,0,32'h00400010));
    push("ip_illop",    st(1,0,0,0,0,1,1,32'h00400020), ex(PCSRC_XADR,0,1,0,0,32'h00400010));
    push("ip_eret",     st(1,0,0,0,1,0,1,32'h80000010), ex(PCSRC_JR,1,0,0,1,32'h00400024));
    push("ip_retrap",   st(1,0,0,0,0,0,1,32'h00400024), ex(PCSRC_ILLOP,0,1,1,0,32'h00400024));
    push("ip_dbl_flt",  st(1,0,0,0,0,1,1,32'h80000040), ex(PCSRC_XADR,0,1,0,1,32'h00400024));
    push("ip_k_branch", st(1,1,0,0,0,0,1,32'h80000044), ex(PCSRC_BRANCH,0,0,0,1,32'h00400024));
    push("ip_eret2",    st(1,0,0,0,1,0,1,32'h80000048), ex(PCSRC_JR,1,0,0,1,32'h00400024));
    push("ip_user",     st(1,0,0,0,0,0,0,32'h00400024), ex(PCSRC_NORMAL,0,0,0,0,32'h00400024));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); #4;
      e = exp_q.pop_front();
      obs = {PCSrc, a_sel_epc, squash, irq_ack, kernel_mode, epc};
      total++;
      if (obs !== e.v) begin
        bad++;
        $display("FAIL %s: got src=%b asel=%b sq=%b ack=%b km=%b epc=%h want src=%b asel=%b sq=%b ack=%b km=%b epc=%h",
                 e.name, obs[38:36], obs[35], obs[34], obs[33], obs[32], obs[31:0],
                 e.v[38:36], e.v[35], e.v[34], e.v[33], e.v[32], e.v[31:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_edge_drop();
    stim_t s; exp_t e; logic [38:0] obs;
    push("ed_edge",   st(1,0,0,0,0,0,1,32'h00400030), ex(PCSRC_NORMAL,0,0,0,0,32'h00400024));
    push("ed_illop",  st(1,0,0,0,0,1,0,32'h00400034), ex(PCSRC_XADR,0,1,0,0,32'h00400024));
    push("ed_merge",  st(1,0,0,0,0,0,1,32'h80000008), ex(PCSRC_NORMAL,0,0,0,1,32'h00400038));
    push("ed_eret",   st(1,0,0,0,1,0,0,32'h8000000C), ex(PCSRC_JR,1,0,0,1,32'h00400038));
    push("ed_take",   st(1,0,0,0,0,0,1,32'h00400038), ex(PCSRC_ILLOP,0,1,1,0,32'h00400038));
    push("ed_eret2",  st(1,0,0,0,1,0,1,32'h80000010), ex(PCSRC_JR,1,0,0,1,32'h00400038));
    push("ed_dropped", st(1,0,0,0,0,0,1,32'h0040003C), ex(PCSRC_NORMAL,0,0,0,0,32'h00400038));
    push("ed_quiet",  st(1,0,0,0,0,0,0,32'h00400040), ex(PCSRC_NORMAL,0,0,0,0,32'h00400038));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); #4;
      e = exp_q.pop_front();
      obs = {PCSrc, a_sel_epc, squash, irq_ack, kernel_mode, epc};
      total++;
      if (obs !== e.v) begin
        bad++;
        $display("FAIL %s: got src=%b asel=%b sq=%b ack=%b km=%b epc=%h want src=%b asel=%b sq=%b ack=%b km=%b epc=%h",
                 e.name, obs[38:36], obs[35], obs[34], obs[33], obs[32], obs[31:0],
                 e.v[38:36], e.v[35], e.v[34], e.v[33], e.v[32], e.v[31:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_eret_user_wrap();
    stim_t s; exp_t e; logic [38:0] obs;
    push("ew_eret_user", st(1,0,0,0,1,0,0,32'hFFFFFFFC), ex(PCSRC_XADR,0,1,0,0,32'h00400038));
    push("ew_wrapped",   st(1,0,0,0,0,0,0,32'h80000008), ex(PCSRC_NORMAL,0,0,0,1,32'h00000000));
    push("ew_k_edge",    st(1,0,0,0,0,0,1,32'h8000000C), ex(PCSRC_NORMAL,0,0,0,1,32'h00000000));
    push("ew_k_held",    st(1,0,1,0,0,0,1,32'h80000010), ex(PCSRC_JUMP,0,0,0,1,32'h00000000));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); #4;
      e = exp_q.pop_front();
      obs = {PCSrc, a_sel_epc, squash, irq_ack, kernel_mode, epc};
      total++;
      if (obs !== e.v) begin
        bad++;
        $display("FAIL %s: got src=%b asel=%b sq=%b ack=%b km=%b epc=%h want src=%b asel=%b sq=%b ack=%b km=%b epc=%h",
                 e.name, obs[38:36], obs[35], obs[34], obs[33], obs[32], obs[31:0],
                 e.v[38:36], e.v[35], e.v[34], e.v[33], e.v[32], e.v[31:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_in_kernel();
    stim_t s; exp_t e; logic [38:0] obs;
    push("rk_assert",  st(0,0,0,0,0,0,1,32'h80000014), ex(PCSRC_NORMAL,0,0,0,1,32'h00000000));
    push("rk_user",    st(1,0,0,0,0,0,1,32'h00400000), ex(PCSRC_NORMAL,0,0,0,0,RST_PC));
    push("rk_no_ack1", st(1,0,0,0,0,0,1,32'h00400004), ex(PCSRC_NORMAL,0,0,0,0,RST_PC));
    push("rk_no_ack2", st(1,0,0,0,0,0,0,32'h00400008), ex(PCSRC_NORMAL,0,0,0,0,RST_PC));
    push("rk_new_edge", st(1,0,0,0,0,0,1,32'h00400040), ex(PCSRC_NORMAL,0,0,0,0,RST_PC));
    push("rk_trap",    st(1,0,0,0,0,0,1,32'h00400044), ex(PCSRC_ILLOP,0,1,1,0,RST_PC));
    push("rk_kernel",  st(1,0,0,0,0,0,0,32'h80000004), ex(PCSRC_NORMAL,0,0,0,1,32'h00400044));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front(); apply(s); #4;
      e = exp_q.pop_front();
      obs = {PCSrc, a_sel_epc, squash, irq_ack, kernel_mode, epc};
      total++;
      if (obs !== e.v) begin
        bad++;
        $display("FAIL %s: got src=%b asel=%b sq=%b ack=%b km=%b epc=%h want src=%b asel=%b sq=%b ack=%b km=%b epc=%h",
                 e.name, obs[38:36], obs[35], obs[34], obs[33], obs[32], obs[31:0],
                 e.v[38:36], e.v[35], e.v[34], e.v[33], e.v[32], e.v[31:0]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    apply(st(0,0,0,0,0,0,0,32'h0));
    @(posedge clk);
    @(negedge clk);
    test_reset();
    test_decode_priority();
    test_irq();
    test_illop_with_pend();
    test_edge_drop();
    test_eret_user_wrap();
    test_reset_in_kernel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
